// File: rtl/overvoltage_pkg.sv
// Shared types and helpers for the over-voltage detector control block.
package overvoltage_pkg;

  localparam int unsigned OTRIP_W = 4;
  localparam int unsigned OTRIP_N = 16;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2
  } ov_state_t;

  function automatic logic [OTRIP_N-1:0] otrip_onehot(input logic [OTRIP_W-1:0] sel);
    logic [OTRIP_N-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/ov_debounce.sv
// Two-flop synchroniser and level debouncer for the raw comparator output.
module ov_debounce #(
  parameter int unsigned DEB_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             raw,
  input  logic [DEB_W-1:0] thresh,
  output logic             filtered
);

  logic             s1;
  logic             s2;
  logic [DEB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // A disagreement must persist for thresh+1 sampled cycles before it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      filtered <= 1'b0;
    end else if (!enable) begin
      cnt      <= '0;
      filtered <= 1'b0;
    end else if (s2 != filtered) begin
      if (cnt == thresh) begin
        filtered <= s2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/overvoltage_ctrl.sv
// Over-voltage detector control: enable/settle sequencing, trip decode, debounce, flag and irq.
// Optional trip event counter enabled by defining OVERVOLTAGE_TRIP_CNT_EN.
module overvoltage_ctrl
  import overvoltage_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned DEB_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena_in,
  input  logic [OTRIP_W-1:0] otrip,
  input  logic [DEB_W-1:0]   deb_cnt,
  input  logic               clr_flag,
  input  logic               ovout,
  output logic               ena,
  output logic [OTRIP_N-1:0] otrip_decoded,
  output logic               ov_valid,
  output logic               ov_flt,
  output logic               ov_flag,
  output logic               ov_irq
`ifdef OVERVOLTAGE_TRIP_CNT_EN
  ,
  output logic [7:0]         trip_cnt
`endif
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  ov_state_t          state_q;
  ov_state_t          state_d;
  logic [15:0]        settle_cnt;
  logic [OTRIP_W-1:0] otrip_q;
  logic               otrip_chg;
  logic               settle_restart;
  logic               deb_enable;
  logic               flt_prev;
  logic               flt_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      otrip_q       <= '0;
      otrip_decoded <= otrip_onehot('0);
    end else begin
      otrip_q       <= otrip;
      otrip_decoded <= otrip_onehot(otrip);
    end
  end

  always_comb begin
    state_d        = state_q;
    otrip_chg      = (otrip_q != otrip);
    settle_restart = 1'b0;
    unique case (state_q)
      OFF: begin
        if (ena_in) begin
          state_d        = SETTLE;
          settle_restart = 1'b1;
        end
      end
      SETTLE: begin
        if (otrip_chg) begin
          settle_restart = 1'b1;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (otrip_chg) begin
          state_d        = SETTLE;
          settle_restart = 1'b1;
        end
      end
      default: state_d = OFF;
    endcase
    if (!ena_in) begin
      state_d        = OFF;
      settle_restart = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OFF;
      settle_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != SETTLE || settle_restart) begin
        settle_cnt <= '0;
      end else begin
        settle_cnt <= settle_cnt + 16'd1;
      end
    end
  end

  assign ena      = (state_q != OFF);
  assign ov_valid = (state_q == ACTIVE);

  // Qualifying with the next state lets ov_flt drop on the same edge that leaves ACTIVE.
  assign deb_enable = (state_q == ACTIVE) && (state_d == ACTIVE);

  ov_debounce #(
    .DEB_W (DEB_W)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (deb_enable),
    .raw      (ovout),
    .thresh   (deb_cnt),
    .filtered (ov_flt)
  );

  assign flt_rise = ov_flt & ~flt_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_prev <= 1'b0;
      ov_irq   <= 1'b0;
      ov_flag  <= 1'b0;
    end else begin
      flt_prev <= ov_flt;
      ov_irq   <= flt_rise;
      ov_flag  <= flt_rise | (ov_flag & ~clr_flag);
    end
  end

`ifdef OVERVOLTAGE_TRIP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trip_cnt <= '0;
    end else if (flt_rise) begin
      if (clr_flag) begin
        trip_cnt <= 8'd1;
      end else if (trip_cnt != 8'hFF) begin
        trip_cnt <= trip_cnt + 8'd1;
      end
    end else if (clr_flag) begin
      trip_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_overvoltage_ctrl.sv
// Scoreboard bench for overvoltage_ctrl: expected output changes are queued with their cycle.
module tb_overvoltage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena_in;
  logic [3:0]  otrip;
  logic [7:0]  deb_cnt;
  logic        clr_flag;
  logic        ovout;
  logic        ena;
  logic [15:0] otrip_decoded;
  logic        ov_valid;
  logic        ov_flt;
  logic        ov_flag;
  logic        ov_irq;
`ifdef OVERVOLTAGE_TRIP_CNT_EN
  logic [7:0]  trip_cnt;
`endif

  overvoltage_ctrl #(
    .SETTLE_CYCLES (64),
    .DEB_W         (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena_in        (ena_in),
    .otrip         (otrip),
    .deb_cnt       (deb_cnt),
    .clr_flag      (clr_flag),
    .ovout         (ovout),
    .ena           (ena),
    .otrip_decoded (otrip_decoded),
    .ov_valid      (ov_valid),
    .ov_flt        (ov_flt),
    .ov_flag       (ov_flag),
    .ov_irq        (ov_irq)
`ifdef OVERVOLTAGE_TRIP_CNT_EN
    ,
    .trip_cnt      (trip_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Observed vector: {ena, ov_valid, ov_flt, ov_irq, ov_flag, otrip_decoded}
  logic [20:0] obs;
  assign obs = {ena, ov_valid, ov_flt, ov_irq, ov_flag, otrip_decoded};

  localparam logic [20:0] RESET_V = {5'b00000, 16'h0001};

  int          q_cyc[$];
  logic [20:0] q_v[$];
  string       q_tag[$];

  logic        e_ena, e_val, e_flt, e_irq, e_flag;
  logic [15:0] e_dec;

  task automatic push(input int c, input string tag);
    q_cyc.push_back(c);
    q_v.push_back({e_ena, e_val, e_flt, e_irq, e_flag, e_dec});
    q_tag.push_back(tag);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  bit          mon_on = 1'b0;
  logic [20:0] last_v;
  int          m_cyc;
  logic [20:0] m_v;
  string       m_tag;

  always @(negedge clk) begin
    if (mon_on && (obs !== last_v)) begin
      checks++;
      if (q_v.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %h at cyc %0d, required no change", obs, cyc);
      end else begin
        m_cyc = q_cyc.pop_front();
        m_v   = q_v.pop_front();
        m_tag = q_tag.pop_front();
        if (m_cyc != cyc || m_v !== obs) begin
          errors++;
          $display("FAIL %s: got %h at cyc %0d, required %h at cyc %0d", m_tag, obs, cyc, m_v, m_cyc);
        end
      end
      last_v = obs;
    end
  end

  int t;

  initial begin
    rst_n = 1'b0; ena_in = 1'b0; otrip = 4'd0; deb_cnt = 8'd4; clr_flag = 1'b0; ovout = 1'b0;
    e_ena = 1'b0; e_val = 1'b0; e_flt = 1'b0; e_irq = 1'b0; e_flag = 1'b0; e_dec = 16'h0001;
    step(3);
    checks++;
    if (obs !== RESET_V) begin
      errors++;
      $display("FAIL reset_state: got %h, required %h", obs, RESET_V);
    end
    last_v = obs;
    mon_on = 1'b1;
    rst_n  = 1'b1;
    step(2);

    // enable with trip 5: settle 64 edges then ACTIVE
    t = cyc; ena_in = 1'b1; otrip = 4'd5;
    e_ena = 1'b1; e_dec = 16'h0020; push(t + 1, "enable_settle");
    e_val = 1'b1; push(t + 65, "settle_done");
    step(66);

    // stable high, deb_cnt=4: 7 edges to ov_flt
    t = cyc; ovout = 1'b1;
    e_flt = 1'b1; push(t + 7, "flt_rise");
    e_irq = 1'b1; e_flag = 1'b1; push(t + 8, "irq_flag");
    e_irq = 1'b0; push(t + 9, "irq_end");
    step(12);
    t = cyc; ovout = 1'b0;
    e_flt = 1'b0; push(t + 7, "flt_fall");
    step(12);

    // 3-cycle glitch must be rejected
    ovout = 1'b1; step(3); ovout = 1'b0; step(10);

    // deb_cnt=0 boundary: 3 edges each way
    t = cyc; deb_cnt = 8'd0; ovout = 1'b1;
    e_flt = 1'b1; push(t + 3, "deb0_rise");
    e_irq = 1'b1; push(t + 4, "deb0_irq");
    e_irq = 1'b0; push(t + 5, "deb0_irq_end");
    step(8);
    t = cyc; ovout = 1'b0;
    e_flt = 1'b0; push(t + 3, "deb0_fall");
    step(6);
    deb_cnt = 8'd4;

    // clr_flag coincident with the set: set wins; then clear alone
    t = cyc; ovout = 1'b1;
    e_flt = 1'b1; push(t + 7, "flt_rise2");
    e_irq = 1'b1; push(t + 8, "irq2");
    e_irq = 1'b0; push(t + 9, "irq2_end");
    step(7); clr_flag = 1'b1; step(1); clr_flag = 1'b0;
    step(4);
    t = cyc; clr_flag = 1'b1;
    e_flag = 1'b0; push(t + 1, "flag_clear");
    step(1); clr_flag = 1'b0;
    step(2);

    // otrip change while ACTIVE with ov_flt=1
    t = cyc; otrip = 4'd9;
    e_val = 1'b0; e_flt = 1'b0; e_dec = 16'h0200; push(t + 1, "otrip_restart");
    e_val = 1'b1; push(t + 65, "resettle_done");
    e_flt = 1'b1; push(t + 70, "flt_after_resettle");
    e_irq = 1'b1; e_flag = 1'b1; push(t + 71, "irq3");
    e_irq = 1'b0; push(t + 72, "irq3_end");
    step(75);

`ifdef OVERVOLTAGE_TRIP_CNT_EN
    deb_cnt = 8'd0;
    for (int i = 0; i < 300; i++) begin
      t = cyc; ovout = 1'b0;
      e_flt = 1'b0; push(t + 3, "tc_fall");
      step(4);
      t = cyc; ovout = 1'b1;
      e_flt = 1'b1; push(t + 3, "tc_rise");
      e_irq = 1'b1; push(t + 4, "tc_irq");
      e_irq = 1'b0; push(t + 5, "tc_irq_end");
      step(6);
    end
    checks++;
    if (trip_cnt !== 8'd255) begin
      errors++;
      $display("FAIL trip_cnt_saturate: got %0d, required 255", trip_cnt);
    end
    t = cyc; clr_flag = 1'b1;
    e_flag = 1'b0; push(t + 1, "tc_flag_clear");
    step(1); clr_flag = 1'b0;
    checks++;
    if (trip_cnt !== 8'd0) begin
      errors++;
      $display("FAIL trip_cnt_clear: got %0d, required 0", trip_cnt);
    end
    deb_cnt = 8'd4;
    step(2);
`endif

    // ena_in low while ov_flt=1: drops with no irq, flag retained
    t = cyc; ena_in = 1'b0; ovout = 1'b0;
    e_ena = 1'b0; e_val = 1'b0; e_flt = 1'b0; push(t + 1, "disable");
    step(3);

    // async reset mid-SETTLE
    t = cyc; ena_in = 1'b1;
    e_ena = 1'b1; push(t + 1, "reenable");
    step(10);
    #2 rst_n = 1'b0;
    e_ena = 1'b0; e_flag = 1'b0; e_dec = 16'h0001; push(cyc, "async_reset_settle");
    step(2);
    t = cyc; rst_n = 1'b1;
    e_ena = 1'b1; e_dec = 16'h0200; push(t + 1, "settle_after_reset");
    e_val = 1'b1; push(t + 65, "active_after_reset");
    step(66);

    // async reset mid-debounce
    ovout = 1'b1;
    step(4);
    rst_n = 1'b0;
    e_ena = 1'b0; e_val = 1'b0; e_dec = 16'h0001; push(cyc, "async_reset_debounce");
    step(2);
    t = cyc; rst_n = 1'b1; ena_in = 1'b0;
    e_dec = 16'h0200; push(t + 1, "decode_after_reset");
    step(4);

    mon_on = 1'b0;
    while (q_v.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: missing change to %h at cyc %0d", q_tag.pop_front(), q_v.pop_front(), q_cyc.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/overvoltage_ctrl.md
Name: overvoltage_ctrl

Overview:
- Digital control and conditioning stage for the over-voltage detector; sits on both sides of the analog macro in the dvdd domain.
- Upstream, it drives the analog enable and the one-hot trip-select bus, and sequences a settle window after enable or trip changes.
- Downstream, it synchronises the raw comparator output, debounces it, and produces a filtered level, a sticky flag and an interrupt pulse.

Parameters:
- SETTLE_CYCLES, 64: clk cycles after enable/trip change before the comparator output is trusted; legal range 1..65535.
- DEB_W, 8: width of the debounce threshold input and the debounce counter.

Ports:
- clk  input  1  block clock (dvdd domain).
- rst_n  input  1  asynchronous active-low reset.
- ena_in  input  1  detector enable request from register file.
- otrip  input  4  trip-level select (binary).
- deb_cnt  input  DEB_W  debounce threshold in cycles.
- clr_flag  input  1  write-1 pulse to clear the sticky flag.
- ovout  input  1  raw comparator output from the analog macro; asynchronous.
- ena  output  1  enable to the analog macro.
- otrip_decoded  output  16  registered one-hot trip select to the analog macro.
- ov_valid  output  1  high only in ACTIVE.
- ov_flt  output  1  debounced over-voltage level.
- ov_flag  output  1  sticky over-voltage flag.
- ov_irq  output  1  one-cycle pulse on each ov_flt rising edge.

Behaviour:
- Reset values: ena=0, otrip_decoded=16'h0001, ov_valid=0, ov_flt=0, ov_flag=0, ov_irq=0. FSM=OFF, counters=0, sync flops=0.
- otrip_decoded is registered from otrip every cycle: bit otrip set, all others clear. It updates one cycle after an otrip change.
- FSM states: OFF, SETTLE, ACTIVE.
  - OFF: ena=0. If ena_in=1, go to SETTLE and load the settle counter with 0.
  - SETTLE: ena=1. The counter increments each cycle. When it reaches SETTLE_CYCLES-1, go to ACTIVE.
  - ACTIVE: ena=1, ov_valid=1.
  - ena_in=0 in any state goes to OFF on the next edge; this has priority over every other transition.
  - An otrip change (registered otrip differs from input) in SETTLE or ACTIVE restarts SETTLE with the counter at 0.
- Sync: 2-flop synchroniser on ovout giving s2. Flops are free-running in all states.
- Debounce, ACTIVE only:
  - If s2 != ov_flt and deb_counter == deb_cnt: ov_flt <= s2, counter <= 0.
  - Else if s2 != ov_flt: counter increments.
  - Else: counter <= 0.
  - Latency from a stable ovout change to ov_flt is deb_cnt+3 edges. deb_cnt=0 gives 3 edges.
  - The counter cannot overflow, because the compare caps it at deb_cnt ≤ 2^DEB_W-1.
- Outside ACTIVE: ov_flt forced 0 and the debounce counter is held at 0. Leaving ACTIVE while ov_flt=1 drops it with no irq.
- deb_cnt changed mid-count: the new value takes effect immediately. If the counter already exceeds the new value, it keeps counting to the wrap point, so software must change deb_cnt only outside ACTIVE.
- ov_irq is high the cycle after ov_flt goes 0→1.
- ov_flag:
  - Set on the ov_flt 0→1 edge (same cycle as ov_irq), cleared by clr_flag.
  - Simultaneous set and clear: set wins.
  - Retained through OFF/SETTLE; cleared only by clr_flag or reset.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro OVERVOLTAGE_TRIP_CNT_EN.
- With it defined: extra output trip_cnt [7:0], reset 0. It increments on every ov_irq and saturates at 255. clr_flag also clears it; simultaneous increment and clear gives 1.
- Without it: port and logic absent, with identical behaviour otherwise.

Decomposition:
- Package overvoltage_pkg:
  - state enum ov_state_t {OFF, SETTLE, ACTIVE}
  - constants OTRIP_W=4, OTRIP_N=16
  - one-hot decode function
- Sub-module ov_debounce, parameterised by DEB_W, containing the synchroniser, debounce counter and ov_flt register. Inputs: clk, rst_n, enable (from ACTIVE), raw, thresh. Output: filtered.
- Top level holds the FSM, otrip register, flag, irq and the optional counter.

Test Plan:
- Reset, then ena_in=1, otrip=4'd5, SETTLE_CYCLES=64 → ena=1 after 1 edge; otrip_decoded=16'h0020; ov_valid=1 exactly 64 edges after entering SETTLE.
- ACTIVE, deb_cnt=4, ovout held high → ov_flt=1 after 7 edges, ov_irq one-cycle pulse, ov_flag=1. ovout then low → ov_flt=0 after 7 edges, no irq.
- ACTIVE, deb_cnt=4, ovout glitch high for 3 cycles → ov_flt, ov_irq and ov_flag stay 0.
- otrip 5→9 while ACTIVE with ov_flt=1 → ov_valid=0 and ov_flt=0 next edge, no irq, otrip_decoded=16'h0200, ov_valid returns after 64 cycles.
- clr_flag pulsed in the same cycle as the ov_flt rising edge → ov_flag=1. clr_flag later alone → ov_flag=0. With OVERVOLTAGE_TRIP_CNT_EN, 300 trip events → trip_cnt=255.
- rst_n dropped asynchronously mid-SETTLE and mid-debounce → all outputs at reset values before the next clk edge; otrip_decoded=16'h0001.
